// File: rtl/led_pattern_pkg.sv
// ----------------------------------------------------------------------------
// led_pattern_pkg
// Shared types for the LED pattern generator.
//   led_mode_t         : 2-bit channel mode (off / on / blink / pulse)
//   mode_starts_high() : level a channel's output takes when it is (re)started
// ----------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } led_mode_t;

    // ON and PULSE begin their first interval lit; OFF and BLINK begin dark.
    function automatic logic mode_starts_high(led_mode_t mode);
        return (mode == MODE_ON) || (mode == MODE_PULSE);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// led_pattern_gen_if
// Configuration write port of the LED pattern generator (valid/ready).
//   cfg_valid  : write request, held by the master until accepted
//   cfg_ready  : generator can take a write
//   cfg_chan   : target channel index (out-of-range values are dropped)
//   cfg_mode   : new mode for the channel
//   cfg_period : new period P (cycle is P+1 ticks)
// Modports: master drives the request, slave (the generator) drives ready.
// ----------------------------------------------------------------------------
interface led_pattern_gen_if #(
    parameter int unsigned CH_W     = 2,
    parameter int unsigned PERIOD_W = 8
) ();
    import led_pattern_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan;
    led_mode_t           cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_mode,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_mode,
        input  cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/led_chan.sv
// ----------------------------------------------------------------------------
// led_chan
// One LED channel: mode, period, tick counter and registered output.
// State only moves on a tick; a load on a tick restarts the channel.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : prescaler strobe, advances the channel
//   load         : apply load_mode/load_period at this tick (restart)
//   load_mode    : mode to load
//   load_period  : period P to load
//   out          : LED drive, straight from a flop
// ----------------------------------------------------------------------------
module led_chan
    import led_pattern_pkg::*;
#(
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                load,
    input  led_mode_t           load_mode,
    input  logic [PERIOD_W-1:0] load_period,
    output logic                out
);

    led_mode_t           mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                out_q, out_d;
    logic                wrap;

    // Last tick of the current P+1 tick cycle.
    assign wrap = (cnt_q == period_q);

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        if (tick) begin
            if (load) begin
                mode_d   = load_mode;
                period_d = load_period;
                cnt_d    = '0;
                out_d    = mode_starts_high(load_mode);
            end else begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                case (mode_q)
                    MODE_OFF:   out_d = 1'b0;
                    MODE_ON:    out_d = 1'b1;
                    MODE_BLINK: out_d = out_q ^ wrap;
                    MODE_PULSE: out_d = wrap;
                    default:    out_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/led_pattern_gen.sv
// ----------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED pattern generator. A shared prescaler strobes `tick`
// once every DIV clocks; each channel plays off / on / blink / pulse with its
// own period. Writes land in a single pending slot and are applied on the
// first tick after acceptance, so a channel only ever restarts on a tick.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg        : configuration write port (slave side, valid/ready)
//   tick       : one-clock prescaler strobe
//   out        : LED drives, one per channel, registered
// ----------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV      = 50_000_000,
    parameter int unsigned PRESC_W  = $clog2(DIV),
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pattern_gen_if.slave    cfg,
    output logic                tick,
    output logic [CHANNELS-1:0] out
);

    localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(DIV - 1);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q, presc_d;

    assign tick    = (presc_q == PrescLast);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending write slot and handshake
    // ------------------------------------------------------------------
    logic                pend_q, pend_d;
    logic                ready_q, ready_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    led_mode_t           mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                accept;
    logic                apply;

    // A slot filled on a tick edge is not yet pending at that edge, so it
    // waits for the following tick.
    assign accept = cfg.cfg_valid && ready_q;
    assign apply  = tick && pend_q;

    always_comb begin
        pend_d   = pend_q;
        chan_d   = chan_q;
        mode_d   = mode_q;
        period_d = period_q;
        if (apply) begin
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d   = 1'b1;
            chan_d   = cfg.cfg_chan;
            mode_d   = cfg.cfg_mode;
            period_d = cfg.cfg_period;
        end
        // Ready mirrors the slot state but comes from its own flop.
        ready_d = !pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
            chan_q   <= '0;
            mode_q   <= MODE_OFF;
            period_q <= '0;
        end else begin
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            chan_q   <= chan_d;
            mode_q   <= mode_d;
            period_q <= period_d;
        end
    end

    assign cfg.cfg_ready = ready_q;

    // ------------------------------------------------------------------
    // Channels. A channel index with no matching instance never loads,
    // which is how out-of-range writes get dropped.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic load;

        assign load = apply && (chan_q == CH_W'(i));

        led_chan #(
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .load        (load),
            .load_mode   (mode_q),
            .load_period (period_q),
            .out         (out[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_gen
// Scoreboard bench for led_pattern_gen (DIV=4, PERIOD_W=8). A 4-channel DUT
// and a 3-channel DUT see identical writes; the 3-channel one must drop
// writes to channel 3. A reference model predicts the LED vector after
// every tick edge from closed-form pattern rules and queues it; a monitor
// pops and compares whenever a DUT tick edge happens.
// ----------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int NCH = 4;
    localparam int DIV = 4;
    localparam int PW  = 8;
    localparam int CHW = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick;
    logic           tick3;
    logic [NCH-1:0] out;
    logic [2:0]     out3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_pattern_gen_if #(.CH_W(CHW), .PERIOD_W(PW)) cfg_if ();
    led_pattern_gen_if #(.CH_W(CHW), .PERIOD_W(PW)) cfg3_if ();

    assign cfg3_if.cfg_valid  = cfg_if.cfg_valid;
    assign cfg3_if.cfg_chan   = cfg_if.cfg_chan;
    assign cfg3_if.cfg_mode   = cfg_if.cfg_mode;
    assign cfg3_if.cfg_period = cfg_if.cfg_period;

    led_pattern_gen #(
        .CHANNELS (NCH),
        .DIV      (DIV),
        .PERIOD_W (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (cfg_if),
        .tick  (tick),
        .out   (out)
    );

    led_pattern_gen #(
        .CHANNELS (3),
        .DIV      (DIV),
        .PERIOD_W (PW)
    ) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (cfg3_if),
        .tick  (tick3),
        .out   (out3)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int             edge_cnt = 0;   // clock edges since reset release
    int             tick_idx = 0;   // tick edges since reset release
    bit             m_pend   = 1'b0;
    int             m_chan, m_mode, m_per;
    int             ch_mode  [NCH];
    int             ch_per   [NCH];
    int             ch_start [NCH];
    logic [NCH-1:0] sb_q[$];

    // LED level k ticks after a channel was (re)started.
    function automatic bit exp_level(int mode, int per, int k);
        case (mode)
            1:       return 1'b1;
            2:       return ((k / (per + 1)) % 2) == 1;
            3:       return (k % (per + 1)) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit             acc;
        bit             is_tick;
        logic [NCH-1:0] e;
        if (!rst_n) begin
            edge_cnt = 0;
            tick_idx = 0;
            m_pend   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ch_mode[i]  = 0;
                ch_per[i]   = 0;
                ch_start[i] = 0;
            end
            sb_q.delete();
            return;
        end
        acc      = (cfg_if.cfg_valid === 1'b1) && !m_pend;
        edge_cnt = edge_cnt + 1;
        is_tick  = (edge_cnt % DIV) == 0;
        if (is_tick) begin
            tick_idx = tick_idx + 1;
            if (m_pend) begin
                if (m_chan < NCH) begin
                    ch_mode[m_chan]  = m_mode;
                    ch_per[m_chan]   = m_per;
                    ch_start[m_chan] = tick_idx;
                end
                m_pend = 1'b0;
            end
        end
        if (acc) begin
            m_pend = 1'b1;
            m_chan = int'(cfg_if.cfg_chan);
            m_mode = int'(cfg_if.cfg_mode);
            m_per  = int'(cfg_if.cfg_period);
        end
        if (is_tick) begin
            for (int i = 0; i < NCH; i++) begin
                e[i] = exp_level(ch_mode[i], ch_per[i], tick_idx - ch_start[i]);
            end
            sb_q.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ch_mode[i]  = 0;
            ch_per[i]   = 0;
            ch_start[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [NCH-1:0] e;
        check("cfg_ready", cfg_if.cfg_ready, !m_pend);
        check("cfg_ready_3ch", cfg3_if.cfg_ready, !m_pend);
        check("tick", tick, ((edge_cnt + 1) % DIV) == 0);
        check("tick_3ch", tick3, ((edge_cnt + 1) % DIV) == 0);
        if (rst_n && tick === 1'b1) begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_after_tick", out, e);
                    check("out_after_tick_3ch", out3, e[2:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic write(int ch, int mode, int per);
        int budget = 10 * DIV + 10;
        cfg_if.cfg_chan   = ch[CHW-1:0];
        cfg_if.cfg_mode   = led_mode_t'(mode[1:0]);
        cfg_if.cfg_period = per[PW-1:0];
        cfg_if.cfg_valid  = 1'b1;
        while (cfg_if.cfg_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("handshake_timeout", 0, 1);
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_chan   = '0;
        cfg_if.cfg_mode   = MODE_OFF;
        cfg_if.cfg_period = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_out_3ch", out3, 0);
        check("reset_ready", cfg_if.cfg_ready, 1);
        check("reset_tick", tick, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back writes: the second one stalls on ready
        write(0, MODE_BLINK, 2);
        write(1, MODE_PULSE, 3);
        write(2, MODE_PULSE, 0);

        // Acceptance on a tick edge
        b = 200;
        while (!(cfg_if.cfg_ready === 1'b1 && tick === 1'b1) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) check("tick_align_timeout", 0, 1);
        write(3, MODE_PULSE, 1);
        repeat (30 * DIV) @(negedge clk);

        // Random reconfiguration, including channel 3 (dropped by dut3)
        for (int n = 0; n < 40; n++) begin
            int ch, md, pr;
            repeat ($urandom_range(0, 12)) @(negedge clk);
            ch = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            pr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
            write(ch, md, pr);
        end
        repeat (15 * DIV) @(negedge clk);

        // Reset with a write pending
        write(3, MODE_ON, 0);
        repeat (2 * DIV + 2) @(negedge clk);
        check("ch3_on_before_reset", out[3], 1);
        write(0, MODE_ON, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", out, 0);
        check("async_reset_out_3ch", out3, 0);
        check("async_reset_ready", cfg_if.cfg_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10 * DIV) @(negedge clk);
        check("pending_discarded", out, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator: the parametrised successor to the single-output free-running blinker. A shared prescaler produces a periodic `tick`. Each of `CHANNELS` outputs runs its own period counter and plays one of four modes: off, on, blink or pulse. Channels are reconfigured at run time through a valid/ready write port, and changes take effect glitch-free on the next tick boundary. The block sits beside board status logic and drives the front-panel LEDs directly.

## Interface
Parameters:
- `CHANNELS`, 4: number of LED outputs (≥1).
- `DIV`, 50_000_000: prescaler divide ratio (≥2). `tick` fires once every `DIV` clocks.
- `PRESC_W`, `$clog2(DIV)`: prescaler counter width (derived).
- `PERIOD_W`, 8: width of the per-channel period field.
- `CH_W`, `CHANNELS>1 ? $clog2(CHANNELS) : 1`: channel index width (derived).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: write request.
- `cfg_ready` out 1: block can accept a write.
- `cfg_chan` in `CH_W`: target channel. Values ≥ `CHANNELS` are accepted and discarded.
- `cfg_mode` in 2: 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
- `cfg_period` in `PERIOD_W`: period value P. A channel's cycle length is P+1 ticks.
- `tick` out 1: one-clock strobe from the prescaler.
- `out` out `CHANNELS`: LED drive, registered.

## Operation
- Prescaler counts 0..DIV-1 and wraps to 0. `tick`=1 exactly in the cycle where the count equals DIV-1.
- Per channel, state is `mode`, `period`, `cnt[PERIOD_W]` and `out[i]`. All of it changes only at a clock edge where `tick`=1.
- At a tick edge, for each channel not being configured:
  - `cnt` becomes 0 if `cnt==period`; otherwise `cnt+1`.
  - OFF: `out` holds 0.
  - ON: `out` holds 1.
  - BLINK: `out` toggles when `cnt==period`. This gives 50% duty with a full cycle of 2·(P+1) ticks.
  - PULSE: `out <= (cnt==period)`. Output is high for exactly one tick interval per P+1 ticks.
- Period P=0:
  - BLINK toggles on every tick.
  - PULSE holds `out` at 1 continuously.
- Config handshake:
  - A write is accepted when `cfg_valid && cfg_ready` at a clock edge.
  - Fields are captured into a single pending slot, and `cfg_ready` drops to 0 from the next cycle.
  - At the first tick edge strictly after acceptance, the pending write is applied to its channel: `mode`/`period` are loaded and `cnt<=0`.
  - On apply, `out` loads 1 for ON or PULSE, and 0 for OFF or BLINK.
  - At that same edge `pending<=0`, so `cfg_ready` returns to 1 in the following cycle.
- If acceptance coincides with a tick edge, the write is not applied at that edge; it waits for the next tick.
- Only the addressed channel restarts. Other channels continue undisturbed.
- `cfg_valid` held while `cfg_ready`=0 is ignored and nothing is lost. The master must hold the request until the handshake.

## Timing
- Reset (asynchronous, `rst_n`=0): prescaler 0, `tick` 0, all `cnt` 0, all modes OFF, all periods 0, `out` all 0, pending 0, `cfg_ready` 1.
- First `tick` occurs DIV cycles after `rst_n` deasserts.
- Config latency runs from the acceptance edge to the `out` change. It is at most DIV cycles and at least 1 cycle.
- `out` is driven directly from flops, with no combinational path from any input.
- `cfg_ready` is driven by a flop.
- Reset asserted mid-operation, including with a write pending, discards everything immediately. The pending write is not applied.

## Structure
- Package `led_pattern_pkg`: mode constants `MODE_OFF`, `MODE_ON`, `MODE_BLINK`, `MODE_PULSE` as a 2-bit typedef `led_mode_t`.
- Sub-module `led_chan`: one channel's `cnt`, `mode`, `period` and `out`. It takes inputs `tick`, `load`, `load_mode` and `load_period`, and is instantiated `CHANNELS` times by a generate loop.
- Top-level owns the prescaler, the pending slot, channel decode and the handshake.

## Test plan
All scenarios use `DIV`=4, `CHANNELS`=4, `PERIOD_W`=8.
- Reset: hold `rst_n`=0 and toggle `clk` → `out`=4'b0000, `cfg_ready`=1. Release → `tick` first high in the 4th cycle, then every 4 cycles.
- BLINK: write ch0 BLINK P=2 → after apply, `out[0]` is 0 for 3 ticks, then 1 for 3 ticks, repeating (24-clock cycle). Other outputs stay 0.
- PULSE and P=0 boundary:
  - Write ch1 PULSE P=3 → `out[1]` is 1 for the apply interval, then 0 for 3 ticks, period 4 ticks.
  - Write ch2 PULSE P=0 → `out[2]` stays 1.
- Handshake back-pressure: accept a write, then hold `cfg_valid` with a second write → `cfg_ready`=0 until the apply tick. The second write is accepted the cycle after apply and applied at the following tick.
- Coincident events:
  - Accept a write on a tick edge → applied one full tick later (4 clocks), not at that edge.
  - Write `cfg_chan`=5 (with `CH_W`=2 this aliases to ch1, so use a `CHANNELS`=3 build) → no `out` change.
- Reset mid-operation: assert `rst_n`=0 while ch3 is ON with a write pending → `out`=0 asynchronously, and after release the pending write never applies.
